regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback sources (ALU, load unit, CSR unit) using round-robin arbitration.
- Keeps a pending-write scoreboard. Issue logic reserves a destination register. The scoreboard reports busy source registers so the microcode sequencer can stall before enabling rs1/rs2 reads.
- Sits between the execute/memory units and the register file write port.

Parameters:
- NUM_REQ, 3, number of writeback requesters (legal 2..8).
- XLEN, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester writeback valid.
- req_ready  output  NUM_REQ  per-requester grant, combinational, one-hot or zero.
- req_addr  input  NUM_REQ*5  packed destination addresses; requester i uses bits [5i+4:5i].
- req_data  input  NUM_REQ*XLEN  packed write data; requester i uses slice i.
- wr_en  output  1  register file write enable, registered.
- wr_addr  output  5  register file write address, registered.
- wr_data  output  XLEN  register file write data, registered.
- rsv_valid  input  1  issue stage reserves a destination register.
- rsv_addr  input  5  address being reserved.
- rsv_ready  output  1  reservation accepted this cycle, combinational.
- rs1_addr  input  5  source address to check.
- rs2_addr  input  5  source address to check.
- rs1_busy  output  1  busy[rs1_addr], combinational from registered state.
- rs2_busy  output  1  busy[rs2_addr].
- busy  output  32  scoreboard bitmap; bit 0 is constant 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, round-robin pointer=0.
  - Any in-flight accepted write is dropped.
  - req_ready and rsv_ready are 0 while rst_n=0.
- Arbitration:
  - Search starts at pointer p and proceeds through p, p+1, … (mod NUM_REQ).
  - The first index with req_valid=1 gets req_ready=1; all others get 0.
  - Transfer occurs when req_valid & req_ready.
  - After a transfer from index g, p <= (g+1) mod NUM_REQ.
  - If no transfer occurs, p holds.
  - At most one transfer per cycle.
  - A requester must hold valid, addr and data stable until ready. The block does not check this.
- Write port:
  - The cycle after a transfer with addr!=0: wr_en=1, wr_addr/wr_data = the transferred values. Latency is 1 cycle.
  - With no transfer: wr_en=0; wr_addr/wr_data hold their last values.
  - A transfer with addr==0 is accepted (ready=1) but produces wr_en=0 and no scoreboard effect.
- Scoreboard:
  - On the edge where wr_en=1, busy[wr_addr] <= 0. This is the same edge the register file captures the data.
  - Writeback to a non-busy register is legal; the bit stays 0.
  - rsv_ready = rst_n & (rsv_addr==0 | ~busy[rsv_addr]). This stalls WAW hazards.
  - On rsv_valid & rsv_ready with rsv_addr!=0: busy[rsv_addr] <= 1.
  - Reserve and clear of the same address cannot coincide, because rsv_ready is 0 while the bit is set.
  - Reserve and clear of different addresses in one cycle both take effect.
  - busy[0] is always 0. rs1_busy/rs2_busy are 0 for address 0.
- No backpressure from the register file: the write port accepts a write every cycle, so full throughput is 1 write/cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN=32, REG_ADDR_W=5, NUM_REGS=32;
  - writeback requester index constants WB_ALU=0, WB_LOAD=1, WB_CSR=2.
- One sub-module, rr_arbiter(N): request vector in, one-hot grant out, pointer register, update-on-accept input.
- The scoreboard and write-port registers stay in the top module.

Test Plan:
- Reset with all inputs active → busy=0, wr_en=0, req_ready=000, rsv_ready=0. After rst_n=1, rsv to x5 → busy=0x00000020.
- All three valid continuously, addrs x1/x2/x3, data 0xA/0xB/0xC → grants 0,1,2,0,… one per cycle. wr_addr sequence 1,2,3,1 with matching data, each one cycle after its grant.
- Reserve x7, then rs1_addr=7 → rs1_busy=1. LOAD writeback x7=0xDEADBEEF → wr_en next cycle; rs1_busy=0 the cycle after that.
- Reserve x7 while busy[7]=1 → rsv_ready=0, busy unchanged. Reserve x0 → rsv_ready=1, busy unchanged.
- Writeback to x0 with data 0x1234 → req_ready=1, wr_en stays 0. Pointer still advances past that requester.
- Transfer accepted, rst_n=0 on the next edge → wr_en=0 and busy=0 after that edge. No write to the register file occurs.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants for the register file and writeback path.
//   XLEN        : datapath width
//   REG_ADDR_W  : register address width
//   NUM_REGS    : number of architectural registers (x0 hardwired to zero)
//   WB_ALU/WB_LOAD/WB_CSR : writeback requester indices on the shared write port
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_CSR  = 2;

endpackage : cpu_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle between the execute/memory units and the
// register-file write-port arbiter.
//
// Handshake: requester i raises req_valid[i] with req_addr/req_data slice i
// and holds all three stable until req_ready[i] is seen high; a transfer
// happens on the rising edge where req_valid[i] & req_ready[i].
//   req_valid : NUM_REQ      per-requester valid (master -> slave)
//   req_ready : NUM_REQ      per-requester grant, one-hot or zero (slave -> master)
//   req_addr  : NUM_REQ*5    packed destination addresses, slice i = [5i+4:5i]
//   req_data  : NUM_REQ*XLEN packed write data, slice i = [XLEN*i +: XLEN]
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*5-1:0]    req_addr;
    logic [NUM_REQ*XLEN-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   req        : N-bit request vector
//   accept     : the granted request was taken this cycle; advance the pointer
//   gnt        : one-hot (or zero) grant, combinational
// The search starts at the pointer and wraps; after an accepted grant to
// index g the pointer moves to g+1 (mod N), otherwise it holds.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = PW + 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    logic [IW-1:0] idx;
    logic          found;

    // Walk the N positions starting at the pointer; the first live request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr_q} + IW'(i);
            if (idx >= IW'(N)) begin
                idx = idx - IW'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[PW-1:0];
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && found) begin
            ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
//   clk, rst_n           : clock, synchronous active-low reset
//   wb (slave modport)   : NUM_REQ writeback requesters (valid/ready/addr/data)
//   wr_en/wr_addr/wr_data: registered register-file write port, 1-cycle latency
//   rsv_valid/rsv_addr   : issue stage reserves a destination register
//   rsv_ready            : reservation accepted (stalls WAW on a busy register)
//   rs1_addr/rs2_addr    : source registers to check
//   rs1_busy/rs2_busy    : pending-write flags for the source registers
//   busy                 : full scoreboard bitmap, bit 0 always 0
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = cpu_pkg::XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_wb_arbiter_if.slave     wb,
    output logic                    wr_en,
    output logic [REG_ADDR_W-1:0]   wr_addr,
    output logic [XLEN-1:0]         wr_data,
    input  logic                    rsv_valid,
    input  logic [REG_ADDR_W-1:0]   rsv_addr,
    output logic                    rsv_ready,
    input  logic [REG_ADDR_W-1:0]   rs1_addr,
    input  logic [REG_ADDR_W-1:0]   rs2_addr,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic [NUM_REGS-1:0]     busy
);
    logic [NUM_REQ-1:0]    req_live;
    logic [NUM_REQ-1:0]    gnt;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] xfer_addr;
    logic [XLEN-1:0]       xfer_data;

    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]       wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    // Masking requests with rst_n keeps every grant low during reset.
    assign req_live = wb.req_valid & {NUM_REQ{rst_n}};

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_live),
        .accept (xfer),
        .gnt    (gnt)
    );

    assign wb.req_ready = gnt;
    // A grant only goes to a valid requester, so any grant is a transfer.
    assign xfer = |gnt;

    always_comb begin
        xfer_addr = '0;
        xfer_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                xfer_addr = wb.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                xfer_data = wb.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_comb begin
        wr_en_d   = xfer && (xfer_addr != '0);
        wr_addr_d = wr_en_d ? xfer_addr : wr_addr_q;
        wr_data_d = wr_en_d ? xfer_data : wr_data_q;
    end

    assign rsv_ready = rst_n && ((rsv_addr == '0) || !busy_q[rsv_addr]);

    // Clear for the outgoing write and set for a new reservation; they never
    // target the same register because rsv_ready is low while the bit is set.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (rsv_valid && rsv_ready && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign rs1_busy = busy_q[rs1_addr];
    assign rs2_busy = busy_q[rs2_addr];

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    typedef struct {
        logic [N-1:0]   v;
        logic [N*5-1:0] addr;
        logic [N*W-1:0] data;
        logic           rsv_v;
        logic [4:0]     rsv_a;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [N-1:0]   e_ready;
        logic           e_rsv_ready;
        logic           e_rs1_busy;
        logic           e_rs2_busy;
        logic           e_wr_en;
        logic [4:0]     e_wr_addr;
        logic [W-1:0]   e_wr_data;
        logic [31:0]    e_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [W-1:0] wr_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy;

    int n_checks = 0;
    int n_err    = 0;

    logic [4+W:0] exp_q[$];

    regfile_wb_arbiter_if #(.NUM_REQ(N), .XLEN(W)) wb ();

    regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wb),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        wb.req_valid = t.v;
        wb.req_addr  = t.addr;
        wb.req_data  = t.data;
        rsv_valid    = t.rsv_v;
        rsv_addr     = t.rsv_a;
        rs1_addr     = t.rs1;
        rs2_addr     = t.rs2;
    endtask

    task automatic idle_inputs();
        wb.req_valid = '0;
        wb.req_addr  = '0;
        wb.req_data  = '0;
        rsv_valid    = 1'b0;
        rsv_addr     = '0;
        rs1_addr     = '0;
        rs2_addr     = '0;
    endtask

    function automatic vec_t mk(
        input logic [N-1:0] v, input logic [N*5-1:0] addr, input logic [N*W-1:0] data,
        input logic rsv_v, input logic [4:0] rsv_a, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [N-1:0] e_ready, input logic e_rsv_ready, input logic e_rs1_busy,
        input logic e_rs2_busy, input logic e_wr_en, input logic [4:0] e_wr_addr,
        input logic [W-1:0] e_wr_data, input logic [31:0] e_busy);
        vec_t t;
        t.v = v; t.addr = addr; t.data = data;
        t.rsv_v = rsv_v; t.rsv_a = rsv_a; t.rs1 = rs1; t.rs2 = rs2;
        t.e_ready = e_ready; t.e_rsv_ready = e_rsv_ready;
        t.e_rs1_busy = e_rs1_busy; t.e_rs2_busy = e_rs2_busy;
        t.e_wr_en = e_wr_en; t.e_wr_addr = e_wr_addr; t.e_wr_data = e_wr_data;
        t.e_busy = e_busy;
        return t;
    endfunction

    // ---------------- reference model state ----------------
    int           ptr_m;
    logic [31:0]  busy_m;
    logic         wr_en_m;
    logic [4:0]   wr_addr_m;
    logic [W-1:0] wr_data_m;

    localparam logic [N*5-1:0] ADDR_123 = {5'd3, 5'd2, 5'd1};
    localparam logic [N*W-1:0] DATA_ABC = {32'hC, 32'hB, 32'hA};

    vec_t vec[12];

    initial begin
        // ---------- reset with every input active ----------
        rst_n        = 1'b0;
        wb.req_valid = '1;
        wb.req_addr  = ADDR_123;
        wb.req_data  = DATA_ABC;
        rsv_valid    = 1'b1;
        rsv_addr     = 5'd5;
        rs1_addr     = 5'd5;
        rs2_addr     = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", W'(wb.req_ready), W'(3'b000));
        chk("reset rsv_ready", W'(rsv_ready), W'(1'b0));
        chk("reset busy", busy, 32'h0);
        chk("reset wr_en", W'(wr_en), W'(1'b0));
        chk("reset wr_addr", W'(wr_addr), W'(5'd0));
        chk("reset wr_data", wr_data, 32'h0);
        rst_n = 1'b1;
        idle_inputs();

        // ---------- directed table ----------
        //          v       addr                  data                      rv  ra  rs1 rs2 | ready rr  b1 b2 we wa  wd            busy
        vec[0]  = mk(3'b000, '0,                   '0,                       1, 5,  5,  0,  3'b000, 1, 0, 0, 0, 0, 32'h0,       32'h20);
        vec[1]  = mk(3'b111, ADDR_123,             DATA_ABC,                 0, 0,  5,  0,  3'b001, 1, 1, 0, 1, 1, 32'hA,       32'h20);
        vec[2]  = mk(3'b111, ADDR_123,             DATA_ABC,                 0, 0,  5,  0,  3'b010, 1, 1, 0, 1, 2, 32'hB,       32'h20);
        vec[3]  = mk(3'b111, ADDR_123,             DATA_ABC,                 0, 0,  5,  0,  3'b100, 1, 1, 0, 1, 3, 32'hC,       32'h20);
        vec[4]  = mk(3'b111, ADDR_123,             DATA_ABC,                 0, 0,  5,  0,  3'b001, 1, 1, 0, 1, 1, 32'hA,       32'h20);
        vec[5]  = mk(3'b000, '0,                   '0,                       1, 7,  7,  0,  3'b000, 1, 0, 0, 0, 1, 32'hA,       32'hA0);
        vec[6]  = mk(3'b010, {5'd0, 5'd7, 5'd0},   {32'h0, 32'hDEADBEEF, 32'h0}, 1, 7, 7, 0, 3'b010, 0, 1, 0, 1, 7, 32'hDEADBEEF, 32'hA0);
        vec[7]  = mk(3'b000, '0,                   '0,                       1, 0,  7,  0,  3'b000, 1, 1, 0, 0, 7, 32'hDEADBEEF, 32'h20);
        vec[8]  = mk(3'b100, '0,                   {32'h1234, 32'h0, 32'h0}, 0, 0,  7,  0,  3'b100, 1, 0, 0, 0, 7, 32'hDEADBEEF, 32'h20);
        vec[9]  = mk(3'b111, ADDR_123,             DATA_ABC,                 1, 4,  0,  4,  3'b001, 1, 0, 0, 1, 1, 32'hA,       32'h30);
        vec[10] = mk(3'b010, {5'd0, 5'd5, 5'd0},   {32'h0, 32'h55, 32'h0},   1, 9,  5,  4,  3'b010, 1, 1, 1, 1, 5, 32'h55,      32'h230);
        vec[11] = mk(3'b000, '0,                   '0,                       1, 6,  5,  4,  3'b000, 1, 1, 1, 0, 5, 32'h55,      32'h250);

        for (int r = 0; r < 12; r++) begin
            apply(vec[r]);
            #1;
            chk($sformatf("row%0d req_ready", r), W'(wb.req_ready), W'(vec[r].e_ready));
            chk($sformatf("row%0d rsv_ready", r), W'(rsv_ready), W'(vec[r].e_rsv_ready));
            chk($sformatf("row%0d rs1_busy", r), W'(rs1_busy), W'(vec[r].e_rs1_busy));
            chk($sformatf("row%0d rs2_busy", r), W'(rs2_busy), W'(vec[r].e_rs2_busy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d wr_en", r), W'(wr_en), W'(vec[r].e_wr_en));
            chk($sformatf("row%0d wr_addr", r), W'(wr_addr), W'(vec[r].e_wr_addr));
            chk($sformatf("row%0d wr_data", r), wr_data, vec[r].e_wr_data);
            chk($sformatf("row%0d busy", r), busy, vec[r].e_busy);
        end

        // ---------- reset drops a write that was about to be accepted ----------
        // Pointer sits at 2 after row 10.
        idle_inputs();
        wb.req_valid = 3'b100;
        wb.req_addr  = {5'd3, 5'd0, 5'd0};
        wb.req_data  = {32'h77, 32'h0, 32'h0};
        rsv_valid    = 1'b1;
        rsv_addr     = 5'd11;
        #1;
        chk("pre-reset req_ready", W'(wb.req_ready), W'(3'b100));
        rst_n = 1'b0;
        #1;
        chk("in-reset req_ready", W'(wb.req_ready), W'(3'b000));
        chk("in-reset rsv_ready", W'(rsv_ready), W'(1'b0));
        @(posedge clk);
        #1;
        chk("post-reset wr_en", W'(wr_en), W'(1'b0));
        chk("post-reset busy", busy, 32'h0);
        rst_n        = 1'b1;
        rsv_valid    = 1'b0;
        wb.req_valid = 3'b111;
        #1;
        chk("post-reset pointer", W'(wb.req_ready), W'(3'b001));

        // Clean restart for the randomized phase.
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        ptr_m     = 0;
        busy_m    = '0;
        wr_en_m   = 1'b0;
        wr_addr_m = '0;
        wr_data_m = '0;

        // ---------- randomized traffic vs reference model ----------
        for (int c = 0; c < 400; c++) begin
            int           g;
            logic [N-1:0] e_ready;
            logic         e_rsv;
            logic [31:0]  busy_n;
            logic [4:0]   a;
            logic [W-1:0] d;

            wb.req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                wb.req_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
                wb.req_data[i*W +: W] = $urandom;
            end
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = 5'($urandom_range(0, 9));
            rs1_addr  = 5'($urandom_range(0, 9));
            rs2_addr  = 5'($urandom_range(0, 9));
            #1;

            // Round-robin: first valid index at or after the pointer, wrapping.
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && wb.req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
            e_ready = (g >= 0) ? N'(1 << g) : '0;
            e_rsv   = (rsv_addr == 0) || !busy_m[rsv_addr];

            chk($sformatf("rnd%0d req_ready", c), W'(wb.req_ready), W'(e_ready));
            chk($sformatf("rnd%0d rsv_ready", c), W'(rsv_ready), W'(e_rsv));
            chk($sformatf("rnd%0d rs1_busy", c), W'(rs1_busy), W'(busy_m[rs1_addr]));
            chk($sformatf("rnd%0d rs2_busy", c), W'(rs2_busy), W'(busy_m[rs2_addr]));

            busy_n = busy_m;
            if (wr_en_m) busy_n[wr_addr_m] = 1'b0;
            if (rsv_valid && e_rsv && rsv_addr != 0) busy_n[rsv_addr] = 1'b1;
            busy_m  = busy_n;
            wr_en_m = 1'b0;
            if (g >= 0) begin
                ptr_m = (g + 1) % N;
                a = wb.req_addr[g*5 +: 5];
                d = wb.req_data[g*W +: W];
                if (a != 0) begin
                    wr_en_m   = 1'b1;
                    wr_addr_m = a;
                    wr_data_m = d;
                    exp_q.push_back({a, d});
                end
            end

            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d wr_en", c), W'(wr_en), W'(wr_en_m));
            chk($sformatf("rnd%0d busy", c), busy, busy_m);
            chk($sformatf("rnd%0d wr_addr", c), W'(wr_addr), W'(wr_addr_m));
            chk($sformatf("rnd%0d wr_data", c), wr_data, wr_data_m);
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("rnd%0d unexpected write addr", c), W'(wr_addr), W'(5'd0));
                end else begin
                    logic [4+W:0] e;
                    e = exp_q.pop_front();
                    chk($sformatf("rnd%0d sb addr", c), W'(wr_addr), W'(e[W +: 5]));
                    chk($sformatf("rnd%0d sb data", c), wr_data, e[W-1:0]);
                end
            end
        end
        chk("sb queue empty", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
